// File: rtl/hwce_types.sv
`default_nettype none
// ============================================================================
// Module      : hwce_types
// Description : Shared state encoding for the HWCE sum-of-products control,
//               datapath and register-file blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package hwce_types;

    localparam int unsigned c_state_w = 4;

    typedef enum logic [c_state_w-1:0] {
        ST_IDLE  = 4'b0000,
        ST_CLEAR = 4'b0001,
        ST_RUN   = 4'b0011,
        ST_DRAIN = 4'b0010,
        ST_DONE  = 4'b0110
    } hwce_state_e;

endpackage
`default_nettype wire

// File: rtl/hwce_ctrl_counter.sv
`default_nettype none
// ============================================================================
// Module      : hwce_ctrl_counter
// Description : Job counter with synchronous clear, increment and a compare of
//               the post-increment value against a terminal count.
// Revision    : 1.0 - initial release
// ============================================================================
module hwce_ctrl_counter
    import hwce_types::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [WIDTH-1:0] i_term,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_term_nxt
);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;

    assign w_cnt_nxt = r_cnt + WIDTH'(i_inc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // Includes this cycle's increment so the FSM can leave on the same edge.
    assign o_term_nxt = (w_cnt_nxt == i_term);
    assign o_cnt      = r_cnt;

endmodule
`default_nettype wire

// File: rtl/hwce_sop_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hwce_sop_ctrl
// Description : Job controller for the HWCE sum-of-products pipeline: launches,
//               streams, drains and checks one job of nb_pixels results.
// Revision    : 1.0 - initial release
// ============================================================================
module hwce_sop_ctrl
    import hwce_types::*;
#(
    parameter int unsigned PIPE_STAGES_SOP = 12,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] nb_pixels,
    input  logic                 x_valid,
    output logic                 x_ready,
    input  logic                 y_ready,
    output logic                 sop_enable,
    output logic                 sop_clear,
    output logic                 sop_valid_x,
    input  logic                 sop_valid_y,
    output logic [3:0]           fsm_state,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int unsigned            c_drain_w   = $clog2(PIPE_STAGES_SOP + 3);
    localparam logic [c_drain_w-1:0]   c_drain_lim = c_drain_w'(PIPE_STAGES_SOP + 2);

    hwce_state_e            r_state;
    hwce_state_e            w_state_nxt;
    logic [CNT_WIDTH-1:0]   r_nb_pixels;
    logic                   r_err;
    logic                   r_zero_done;

    logic                   w_idle;
    logic                   w_run;
    logic                   w_drain;
    logic                   w_accept;
    logic                   w_start_acc;
    logic                   w_out_inc;
    logic                   w_drain_inc;
    logic [CNT_WIDTH-1:0]   w_in_cnt;
    logic [CNT_WIDTH-1:0]   w_out_cnt;
    logic [c_drain_w-1:0]   w_drain_cnt;
    logic                   w_in_term;
    logic                   w_out_term;
    logic                   w_drain_term;
    logic                   w_drain_tmo;
    logic [CNT_WIDTH:0]     w_in_tot;
    logic [CNT_WIDTH:0]     w_out_tot;
    logic                   w_err_set;
    logic                   w_unused;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_run       = (r_state == ST_RUN);
    assign w_drain     = (r_state == ST_DRAIN);
    assign w_start_acc = w_idle & start;

    assign x_ready     = w_run & y_ready;
    assign w_accept    = x_valid & x_ready;
    assign sop_valid_x = w_accept;
    assign sop_enable  = w_run | w_drain;
    assign sop_clear   = (r_state == ST_CLEAR);

    assign w_out_inc   = sop_valid_y & y_ready & (w_run | w_drain);
    assign w_drain_inc = w_drain & y_ready;

    hwce_ctrl_counter #(.WIDTH(CNT_WIDTH)) u_in_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (sop_clear),
        .i_inc      (w_accept),
        .i_term     (r_nb_pixels),
        .o_cnt      (w_in_cnt),
        .o_term_nxt (w_in_term)
    );

    hwce_ctrl_counter #(.WIDTH(CNT_WIDTH)) u_out_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (sop_clear),
        .i_inc      (w_out_inc),
        .i_term     (r_nb_pixels),
        .o_cnt      (w_out_cnt),
        .o_term_nxt (w_out_term)
    );

    hwce_ctrl_counter #(.WIDTH(c_drain_w)) u_drain_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (sop_clear),
        .i_inc      (w_drain_inc),
        .i_term     (c_drain_lim),
        .o_cnt      (w_drain_cnt),
        .o_term_nxt (w_drain_term)
    );

    // The drain count only matters through its terminal compare.
    assign w_unused    = ^w_drain_cnt;

    assign w_drain_tmo = w_drain_inc & w_drain_term & ~w_out_term;

    // One extra bit so a result arriving beyond the inputs cannot wrap.
    assign w_in_tot  = {1'b0, w_in_cnt}  + {{CNT_WIDTH{1'b0}}, w_accept};
    assign w_out_tot = {1'b0, w_out_cnt} + {{CNT_WIDTH{1'b0}}, w_out_inc};

    assign w_err_set = (sop_valid_y & ~(w_run | w_drain))
                     | (w_out_tot > w_in_tot)
                     | w_drain_tmo;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start && (nb_pixels != '0)) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (w_accept && w_in_term) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_out_term || w_drain_tmo) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_nb_pixels <= '0;
            r_err       <= 1'b0;
            r_zero_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_zero_done <= w_start_acc & (nb_pixels == '0);
            if (w_start_acc) begin
                r_nb_pixels <= nb_pixels;
            end
            // A new fault in the launching cycle still wins over the clear.
            r_err       <= w_err_set | (r_err & ~w_start_acc);
        end
    end

    assign fsm_state = r_state;
    assign busy      = ~w_idle;
    assign done      = (r_state == ST_DONE) | r_zero_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_hwce_sop_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hwce_sop_ctrl
// Description : Directed self-checking bench for hwce_sop_ctrl with a small
//               enable-gated pipeline model standing in for the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hwce_sop_ctrl;

    localparam int MODEL_D = 11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] nb_pixels = '0;
    logic        x_valid = 1'b0;
    logic        x_ready;
    logic        y_ready = 1'b0;
    logic        sop_enable;
    logic        sop_clear;
    logic        sop_valid_x;
    logic        sop_valid_y;
    logic [3:0]  fsm_state;
    logic        busy;
    logic        done;
    logic        err;

    int n_total = 0;
    int n_pass  = 0;

    logic [MODEL_D-1:0] pipe = '0;
    int                 in_seen = 0;
    int                 drop_idx = -1;
    logic               force_vy = 1'b0;

    logic [31:0] vx_mask;
    int          done_cyc, done_count, clear_count, err_cyc, stall_bad;
    logic        busy_seen;

    hwce_sop_ctrl #(.PIPE_STAGES_SOP(12), .CNT_WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .nb_pixels   (nb_pixels),
        .x_valid     (x_valid),
        .x_ready     (x_ready),
        .y_ready     (y_ready),
        .sop_enable  (sop_enable),
        .sop_clear   (sop_clear),
        .sop_valid_x (sop_valid_x),
        .sop_valid_y (sop_valid_y),
        .fsm_state   (fsm_state),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Datapath model: a result appears 11 advancing edges after its window,
    // i.e. in the 12th cycle counting the input cycle; frozen unless enabled.
    always @(posedge clk) begin
        if (sop_clear) begin
            pipe    <= '0;
            in_seen <= 0;
        end else if (sop_enable && y_ready) begin
            pipe <= {pipe[MODEL_D-2:0], sop_valid_x && (in_seen != drop_idx)};
            if (sop_valid_x) in_seen <= in_seen + 1;
        end
    end
    assign sop_valid_y = pipe[MODEL_D-1] | force_vy;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    // Cycle 0 is the cycle carrying start; entered and left just after a rising edge.
    task automatic run_job(input logic [15:0] nb, input int stall_from, input int stall_len,
                           input int ncyc);
        vx_mask     = '0;
        done_cyc    = -1;
        done_count  = 0;
        clear_count = 0;
        err_cyc     = -1;
        stall_bad   = 0;
        busy_seen   = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            start     = (c == 0);
            nb_pixels = nb;
            x_valid   = 1'b1;
            y_ready   = !(c >= stall_from && c < stall_from + stall_len);
            @(negedge clk);
            if (sop_valid_x && c < 32) vx_mask[c] = 1'b1;
            if (done) begin
                done_count++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (sop_clear) clear_count++;
            if (busy) busy_seen = 1'b1;
            if (err && c >= 1 && err_cyc < 0) err_cyc = c;
            if (!y_ready && (x_ready || sop_valid_x)) stall_bad++;
            @(posedge clk);
            #1;
        end
        start   = 1'b0;
        x_valid = 1'b0;
        y_ready = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", 32'(fsm_state), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_x_ready", 32'(x_ready), 32'd0);
        check("rst_enable", 32'(sop_enable), 32'd0);
        check("rst_clear", 32'(sop_clear), 32'd0);
        check("rst_valid_x", 32'(sop_valid_x), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        y_ready = 1'b1;
        @(posedge clk);
        #1;

        // Four pixels, no back-pressure.
        run_job(16'd4, -1, 0, 20);
        check("t1_vx_mask", vx_mask, 32'h0000_003C);
        check("t1_done_cyc", done_cyc, 17);
        check("t1_done_count", done_count, 1);
        check("t1_clear_count", clear_count, 1);
        check("t1_err_cyc", err_cyc, -1);

        // Three pixels, y_ready low cycles 3..7.
        run_job(16'd3, 3, 5, 24);
        check("t2_vx_mask", vx_mask, 32'h0000_0304);
        check("t2_done_cyc", done_cyc, 21);
        check("t2_stall_bad", stall_bad, 0);
        check("t2_done_count", done_count, 1);
        check("t2_err_cyc", err_cyc, -1);

        // Two pixels, first result lost: drain timeout.
        drop_idx = 0;
        run_job(16'd2, -1, 0, 22);
        drop_idx = -1;
        check("t3_vx_mask", vx_mask, 32'h0000_000C);
        check("t3_err_cyc", err_cyc, 18);
        check("t3_done_cyc", done_cyc, 18);
        check("t3_err_sticky", 32'(err), 32'd1);
        check("t3_state_idle", 32'(fsm_state), 32'd0);

        // Zero-length job.
        run_job(16'd0, -1, 0, 4);
        check("t4_done_cyc", done_cyc, 1);
        check("t4_done_count", done_count, 1);
        check("t4_clear_count", clear_count, 0);
        check("t4_busy_seen", 32'(busy_seen), 32'd0);
        check("t4_err_cleared", 32'(err), 32'd0);

        // Stray result in IDLE.
        force_vy = 1'b1;
        @(negedge clk);
        check("t5_err_before", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        force_vy = 1'b0;
        @(negedge clk);
        check("t5_err_set", 32'(err), 32'd1);
        @(posedge clk);
        #1;
        run_job(16'd1, -1, 0, 16);
        check("t5_err_cyc", err_cyc, -1);
        check("t5_done_cyc", done_cyc, 14);
        check("t5_vx_mask", vx_mask, 32'h0000_0004);

        // Reset in DRAIN, then a one-pixel job.
        run_job(16'd4, -1, 0, 8);
        check("t6_in_drain", 32'(fsm_state), 32'd2);
        check("t6_busy_pre", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_state", 32'(fsm_state), 32'd0);
        check("t6_async_busy", 32'(busy), 32'd0);
        check("t6_async_enable", 32'(sop_enable), 32'd0);
        check("t6_async_done", 32'(done), 32'd0);
        check("t6_async_x_ready", 32'(x_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        done_count = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) done_count++;
        end
        check("t6_no_done", done_count, 0);
        @(posedge clk);
        #1;
        run_job(16'd1, -1, 0, 16);
        check("t6_done_cyc", done_cyc, 14);
        check("t6_done_count", done_count, 1);
        check("t6_err_cyc", err_cyc, -1);
        check("t6_vx_mask", vx_mask, 32'h0000_0004);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
